// File: rtl/vga_timing_ctrl.sv
// VGA timing controller: pixel-rate divider, scan counters, framebuffer fetch and a
// tick-aligned delay line that keeps sync/de lined up with the returned pixel data.
module vga_timing_ctrl #(
    parameter int CLK_DIV    = 4,
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit SYNC_POL   = 1'b0,
    parameter int RD_LATENCY = 2
) (
    input  logic        clk_in1,
    input  logic        reset,
    input  logic        en,
    output logic        pix_tick,
    output logic        fetch_en,
    output logic [9:0]  fetch_x,
    output logic [9:0]  fetch_y,
    input  logic [11:0] rgb_in,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = $clog2(CLK_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0]      div_q, div_d;
    logic [9:0]            h_q, h_d, v_q, v_d;
    logic                  fetch_en_q, fetch_en_d;
    logic [9:0]            fetch_x_q, fetch_x_d, fetch_y_q, fetch_y_d;
    logic [RD_LATENCY-1:0] pen_q, pen_d, phs_q, phs_d, pvs_q, pvs_d;
    logic                  de_q, de_d, hsync_q, hsync_d, vsync_q, vsync_d;
    logic [11:0]           rgb_q, rgb_d;
    logic                  frame_start_q, frame_start_d;
    logic                  tick, hs_raw, vs_raw;

    assign tick   = en && (div_q == DIV_LAST);
    assign hs_raw = (fetch_x_q >= HS_START) && (fetch_x_q < HS_END);
    assign vs_raw = (fetch_y_q >= VS_START) && (fetch_y_q < VS_END);

    // Sync ranges are decoded from the address currently on the fetch port, so they
    // enter the delay line in step with fetch_en and meet the returned data together.
    always_comb begin
        div_d         = div_q;
        h_d           = h_q;
        v_d           = v_q;
        fetch_en_d    = fetch_en_q;
        fetch_x_d     = fetch_x_q;
        fetch_y_d     = fetch_y_q;
        pen_d         = pen_q;
        phs_d         = phs_q;
        pvs_d         = pvs_q;
        de_d          = de_q;
        rgb_d         = rgb_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        frame_start_d = 1'b0;
        if (!en) begin
            div_d   = '0;
            de_d    = 1'b0;
            rgb_d   = '0;
            hsync_d = ~SYNC_POL;
            vsync_d = ~SYNC_POL;
        end else begin
            div_d = tick ? '0 : div_q + 1'b1;
            if (tick) begin
                h_d = (h_q == H_LAST) ? '0 : h_q + 10'd1;
                if (h_q == H_LAST)
                    v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
                fetch_x_d     = h_q;
                fetch_y_d     = v_q;
                fetch_en_d    = (h_q < H_ACT) && (v_q < V_ACT);
                frame_start_d = (h_q == '0) && (v_q == '0);
                pen_d[0] = fetch_en_q;
                phs_d[0] = hs_raw;
                pvs_d[0] = vs_raw;
                for (int i = 1; i < RD_LATENCY; i++) begin
                    pen_d[i] = pen_q[i-1];
                    phs_d[i] = phs_q[i-1];
                    pvs_d[i] = pvs_q[i-1];
                end
                de_d    = pen_q[RD_LATENCY-1];
                rgb_d   = pen_q[RD_LATENCY-1] ? rgb_in : 12'h000;
                hsync_d = phs_q[RD_LATENCY-1] ? SYNC_POL : ~SYNC_POL;
                vsync_d = pvs_q[RD_LATENCY-1] ? SYNC_POL : ~SYNC_POL;
            end
        end
    end

    always_ff @(posedge clk_in1 or negedge reset) begin
        if (!reset) begin
            div_q         <= '0;
            h_q           <= '0;
            v_q           <= '0;
            fetch_en_q    <= 1'b0;
            fetch_x_q     <= '0;
            fetch_y_q     <= '0;
            pen_q         <= '0;
            phs_q         <= '0;
            pvs_q         <= '0;
            de_q          <= 1'b0;
            rgb_q         <= '0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            h_q           <= h_d;
            v_q           <= v_d;
            fetch_en_q    <= fetch_en_d;
            fetch_x_q     <= fetch_x_d;
            fetch_y_q     <= fetch_y_d;
            pen_q         <= pen_d;
            phs_q         <= phs_d;
            pvs_q         <= pvs_d;
            de_q          <= de_d;
            rgb_q         <= rgb_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign pix_tick    = tick;
    assign fetch_en    = fetch_en_q;
    assign fetch_x     = fetch_x_q;
    assign fetch_y     = fetch_y_q;
    assign vga_r       = rgb_q[11:8];
    assign vga_g       = rgb_q[7:4];
    assign vga_b       = rgb_q[3:0];
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Randomized bench for vga_timing_ctrl with a small raster; expected pins are derived
// from the tick count since reset, and a latency-2 framebuffer model feeds rgb_in.
module tb_vga_timing_ctrl;

    localparam int CLK_DIV    = 4;
    localparam int H_ACTIVE   = 12;
    localparam int H_FP       = 3;
    localparam int H_SYNC     = 4;
    localparam int H_BP       = 5;
    localparam int V_ACTIVE   = 6;
    localparam int V_FP       = 2;
    localparam int V_SYNC     = 2;
    localparam int V_BP       = 3;
    localparam bit SYNC_POL   = 1'b0;
    localparam int RD_LATENCY = 2;
    localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FRAME      = H_TOTAL * V_TOTAL;

    logic        clk_in1 = 1'b0;
    logic        reset;
    logic        en;
    logic [11:0] rgb_in;
    logic        pix_tick, fetch_en, hsync, vsync, de, frame_start;
    logic [9:0]  fetch_x, fetch_y;
    logic [3:0]  vga_r, vga_g, vga_b;

    int n_checks = 0;
    int n_fail   = 0;
    int t_cnt;
    int d_cnt;
    logic        exp_fetch_en, exp_fs, exp_de, exp_hs, exp_vs;
    logic [9:0]  exp_fx, exp_fy;
    logic [11:0] exp_rgb;
    logic [19:0] fb_q[$];

    vga_timing_ctrl #(
        .CLK_DIV(CLK_DIV), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .SYNC_POL(SYNC_POL), .RD_LATENCY(RD_LATENCY)
    ) dut (
        .clk_in1(clk_in1), .reset(reset), .en(en), .pix_tick(pix_tick),
        .fetch_en(fetch_en), .fetch_x(fetch_x), .fetch_y(fetch_y), .rgb_in(rgb_in),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .hsync(hsync), .vsync(vsync),
        .de(de), .frame_start(frame_start)
    );

    always #5 clk_in1 = ~clk_in1;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [11:0] pixel(input int x, input int y);
        return {x[3:0], y[3:0], 4'hA};
    endfunction

    task automatic model_reset();
        t_cnt = 0; d_cnt = 0;
        exp_fetch_en = 1'b0; exp_fx = '0; exp_fy = '0; exp_fs = 1'b0;
        exp_de = 1'b0; exp_rgb = '0; exp_hs = ~SYNC_POL; exp_vs = ~SYNC_POL;
    endtask

    // Tick t fetches raster position t mod FRAME; the pins after tick t show position t-3.
    task automatic model_tick();
        int p, s, x, y;
        p = t_cnt % FRAME;
        exp_fx       = 10'(p % H_TOTAL);
        exp_fy       = 10'(p / H_TOTAL);
        exp_fetch_en = (p % H_TOTAL < H_ACTIVE) && (p / H_TOTAL < V_ACTIVE);
        exp_fs       = (p == 0);
        s = t_cnt - RD_LATENCY - 1;
        if (s < 0) begin
            exp_de = 1'b0; exp_rgb = '0; exp_hs = ~SYNC_POL; exp_vs = ~SYNC_POL;
        end else begin
            x = (s % FRAME) % H_TOTAL;
            y = (s % FRAME) / H_TOTAL;
            exp_de  = (x < H_ACTIVE) && (y < V_ACTIVE);
            exp_hs  = (x >= H_ACTIVE + H_FP && x < H_ACTIVE + H_FP + H_SYNC) ? SYNC_POL : ~SYNC_POL;
            exp_vs  = (y >= V_ACTIVE + V_FP && y < V_ACTIVE + V_FP + V_SYNC) ? SYNC_POL : ~SYNC_POL;
            exp_rgb = exp_de ? pixel(x, y) : 12'h000;
        end
        t_cnt++;
    endtask

    task automatic check_regs();
        checkOutput("fetch_en", 32'(fetch_en), 32'(exp_fetch_en));
        checkOutput("fetch_x", 32'(fetch_x), 32'(exp_fx));
        checkOutput("fetch_y", 32'(fetch_y), 32'(exp_fy));
        checkOutput("frame_start", 32'(frame_start), 32'(exp_fs));
        checkOutput("de", 32'(de), 32'(exp_de));
        checkOutput("hsync", 32'(hsync), 32'(exp_hs));
        checkOutput("vsync", 32'(vsync), 32'(exp_vs));
        checkOutput("rgb", 32'({vga_r, vga_g, vga_b}), 32'(exp_rgb));
    endtask

    // One clk_in1 cycle, entered and left at a falling edge.
    task automatic do_cycle(input logic rst_v, input logic en_v);
        logic        tick_exp;
        logic [19:0] a;
        check_regs();
        reset = rst_v;
        en    = en_v;
        #1;
        if (!rst_v) begin
            model_reset();
            fb_q.delete();
            check_regs();
        end
        tick_exp = rst_v && en_v && (d_cnt == CLK_DIV - 1);
        checkOutput("pix_tick", 32'(pix_tick), 32'(tick_exp));
        rgb_in = 12'($urandom);
        if (pix_tick) begin
            fb_q.push_back({fetch_x, fetch_y});
            if (fb_q.size() > RD_LATENCY) begin
                a = fb_q.pop_front();
                rgb_in = pixel(int'(a[19:10]), int'(a[9:0]));
            end
        end
        @(posedge clk_in1);
        if (rst_v) begin
            if (!en_v) begin
                d_cnt = 0; exp_fs = 1'b0;
                exp_de = 1'b0; exp_rgb = '0; exp_hs = ~SYNC_POL; exp_vs = ~SYNC_POL;
            end else if (d_cnt == CLK_DIV - 1) begin
                d_cnt = 0;
                model_tick();
            end else begin
                d_cnt++;
                exp_fs = 1'b0;
            end
        end
        @(negedge clk_in1);
    endtask

    task automatic applyStimulus(input logic rst_v, input logic en_v, input int n);
        repeat (n) do_cycle(rst_v, en_v);
    endtask

    task automatic run_until(input int pos);
        int budget;
        budget = 2 * FRAME * CLK_DIV + 10;
        while (!((t_cnt % FRAME) == pos && d_cnt == 0) && budget > 0) begin
            do_cycle(1'b1, 1'b1);
            budget--;
        end
        checkOutput("reach_pos", 32'(budget > 0), 32'd1);
    endtask

    initial begin
        int r;
        reset  = 1'b0;
        en     = 1'b0;
        rgb_in = '0;
        model_reset();
        @(negedge clk_in1);
        applyStimulus(1'b0, 1'b1, 5);
        applyStimulus(1'b1, 1'b1, 3 * FRAME * CLK_DIV);
        run_until(3 * H_TOTAL + 5);
        applyStimulus(1'b1, 1'b0, 50);
        applyStimulus(1'b1, 1'b1, 2 * H_TOTAL * CLK_DIV);
        run_until(8 * H_TOTAL + 20);
        applyStimulus(1'b0, 1'b1, 2);
        applyStimulus(1'b1, 1'b1, FRAME * CLK_DIV + 40);
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            if (r < 6)
                applyStimulus(1'b1, 1'b1, $urandom_range(20, 400));
            else if (r < 9)
                applyStimulus(1'b1, 1'b0, $urandom_range(1, 30));
            else
                applyStimulus(1'b0, 1'($urandom_range(0, 1)), $urandom_range(1, 3));
        end
        applyStimulus(1'b1, 1'b1, 2 * FRAME * CLK_DIV);
        check_regs();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
